text_wr_arbiter: RTL and testbench

Shares the single write port of the text-screen character memory among two client requesters and an internal clear engine. Requester 0 is the host/text path and requester 1 is the game unit. The block sits in the VGA control layer between the clients and the text_screen write inputs. It drives one registered write per accepted request and can sweep all 80×60 cells to a fill character on command. Writes can optionally be held off until vertical blanking, which avoids mid-frame tearing.

---
 rtl/vga_pkg.sv | 19 +
 rtl/rr_arb2.sv | 38 +++
 rtl/text_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_text_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared text-screen geometry, address packing and arbiter state type
package vga_pkg;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 60;

    typedef logic [13:0] text_addr_t;

    typedef enum logic {
        IDLE,
        CLEAR
    } arb_state_t;

    // Character memory address: bit 13 unused, then row, then column.
    function automatic text_addr_t pack_text_addr(input logic [5:0] row, input logic [6:0] col);
        return {1'b0, row, col};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter with served-last pointer
// Ports: clk_25, resetN (async active-low), valid[1:0] requests, enable gates
// all grants, grant[1:0] one-hot combinational grant. The pointer advances on
// every grant.
module rr_arb2 (
    input  logic       clk_25,
    input  logic       resetN,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    // 1 = requester 1 was served last, so requester 0 wins the next tie.
    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            last <= 1'b1;
        end else if (grant[0]) begin
            last <= 1'b0;
        end else if (grant[1]) begin
            last <= 1'b1;
        end
    end

endmodule

// File: rtl/text_wr_arbiter.sv
// rtl/text_wr_arbiter.sv - text-screen write port arbiter with full-screen clear engine
// Ports: clk_25, resetN (async active-low); req_valid/req_col/req_row/req_char
// in and req_ready out per requester (0 = host, 1 = game); clr_start pulse;
// v_blank; text_add/text_data/wr_en registered write port; busy, clr_done, drop.
// Option macro TEXT_ARB_FRAME_SYNC_EN: grants and clear writes only while v_blank=1.
module text_wr_arbiter
    import vga_pkg::*;
#(
    parameter int         COLS      = TEXT_COLS,
    parameter int         ROWS      = TEXT_ROWS,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic            clk_25,
    input  logic            resetN,
    input  logic [1:0]      req_valid,
    input  logic [1:0][6:0] req_col,
    input  logic [1:0][5:0] req_row,
    input  logic [1:0][7:0] req_char,
    output logic [1:0]      req_ready,
    input  logic            clr_start,
    input  logic            v_blank,
    output logic [13:0]     text_add,
    output logic [7:0]      text_data,
    output logic            wr_en,
    output logic            busy,
    output logic            clr_done,
    output logic            drop
);

    localparam logic [6:0] COL_LAST = 7'(COLS - 1);
    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    arb_state_t state;
    logic [6:0] clr_col;
    logic [5:0] clr_row;

    // slot_ok marks cycles in which a grant or a clear write may happen.
    logic slot_ok;
`ifdef TEXT_ARB_FRAME_SYNC_EN
    assign slot_ok = v_blank;
`else
    logic unused_v_blank;
    assign unused_v_blank = v_blank;
    assign slot_ok        = 1'b1;
`endif

    logic [1:0] grant;
    logic       arb_en;

    // No grant in the clr_start cycle so a request can never slip in ahead of the clear.
    assign arb_en = resetN && (state == IDLE) && !clr_start && slot_ok;

    rr_arb2 u_rr_arb2 (
        .clk_25 (clk_25),
        .resetN (resetN),
        .valid  (req_valid),
        .enable (arb_en),
        .grant  (grant)
    );

    assign req_ready = grant;

    logic       sel;
    logic [6:0] sel_col;
    logic [5:0] sel_row;
    logic [7:0] sel_char;
    logic       in_range;

    assign sel      = grant[1];
    assign sel_col  = req_col[sel];
    assign sel_row  = req_row[sel];
    assign sel_char = req_char[sel];
    assign in_range = (sel_col <= COL_LAST) && (sel_row <= ROW_LAST);

    // Cell written by the clear engine this edge: (0,0) when starting, else the counters.
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic       cur_last;
    logic [6:0] nxt_col;
    logic [5:0] nxt_row;

    always_comb begin
        cur_col  = (state == CLEAR) ? clr_col : 7'd0;
        cur_row  = (state == CLEAR) ? clr_row : 6'd0;
        cur_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        nxt_col  = cur_col + 7'd1;
        nxt_row  = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = 7'd0;
            nxt_row = cur_row + 6'd1;
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            clr_col   <= 7'd0;
            clr_row   <= 6'd0;
            text_add  <= 14'd0;
            text_data <= 8'd0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            clr_done  <= 1'b0;
            drop      <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            drop     <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        clr_col <= 7'd0;
                        clr_row <= 6'd0;
                        if (slot_ok) begin
                            wr_en     <= 1'b1;
                            text_add  <= pack_text_addr(cur_row, cur_col);
                            text_data <= FILL_CHAR;
                            clr_done  <= cur_last;
                            clr_col   <= nxt_col;
                            clr_row   <= nxt_row;
                        end
                    end else if (|grant) begin
                        if (in_range) begin
                            wr_en     <= 1'b1;
                            text_add  <= pack_text_addr(sel_row, sel_col);
                            text_data <= sel_char;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    // clr_done high means the final write is on the port right now.
                    if (clr_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (slot_ok) begin
                        wr_en     <= 1'b1;
                        text_add  <= pack_text_addr(cur_row, cur_col);
                        text_data <= FILL_CHAR;
                        clr_done  <= cur_last;
                        clr_col   <= nxt_col;
                        clr_row   <= nxt_row;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_wr_arbiter.sv
// tb/tb_text_wr_arbiter.sv - directed table-driven bench for text_wr_arbiter
module tb_text_wr_arbiter;

    logic            clk_25 = 1'b0;
    logic            resetN;
    logic [1:0]      req_valid;
    logic [1:0][6:0] req_col;
    logic [1:0][5:0] req_row;
    logic [1:0][7:0] req_char;
    logic [1:0]      req_ready;
    logic            clr_start;
    logic            v_blank;
    logic [13:0]     text_add;
    logic [7:0]      text_data;
    logic            wr_en;
    logic            busy;
    logic            clr_done;
    logic            drop;

    int n_cmp = 0;
    int n_err = 0;

    text_wr_arbiter dut (
        .clk_25    (clk_25),
        .resetN    (resetN),
        .req_valid (req_valid),
        .req_col   (req_col),
        .req_row   (req_row),
        .req_char  (req_char),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .v_blank   (v_blank),
        .text_add  (text_add),
        .text_data (text_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .clr_done  (clr_done),
        .drop      (drop)
    );

    always #20 clk_25 = ~clk_25;

    typedef struct {
        logic [1:0]  v;
        logic [6:0]  c0;
        logic [5:0]  r0;
        logic [7:0]  d0;
        logic [6:0]  c1;
        logic [5:0]  r1;
        logic [7:0]  d1;
        logic [1:0]  rdy;
        logic        wr;
        logic [13:0] add;
        logic [7:0]  data;
        logic        drp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    initial begin
        int wr_cnt, busy_cnt, e_add, e_rdy, e_done, guard;
        int mcol, mrow;
        logic [13:0] last_add;

        // Pointer starts at "1 served last"; each row's expectation follows the previous grant.
        vecs[0] = '{2'b01, 7'd5,  6'd2,  8'h41, 7'd0,  6'd0,  8'h00, 2'b01, 1'b1, 14'h0105, 8'h41, 1'b0};
        vecs[1] = '{2'b11, 7'd10, 6'd3,  8'h42, 7'd7,  6'd1,  8'h43, 2'b10, 1'b1, 14'h0087, 8'h43, 1'b0};
        vecs[2] = '{2'b11, 7'd10, 6'd3,  8'h42, 7'd7,  6'd1,  8'h43, 2'b01, 1'b1, 14'h018A, 8'h42, 1'b0};
        vecs[3] = '{2'b10, 7'd0,  6'd0,  8'h00, 7'd79, 6'd59, 8'h44, 2'b10, 1'b1, 14'h1DCF, 8'h44, 1'b0};
        vecs[4] = '{2'b01, 7'd80, 6'd0,  8'h45, 7'd0,  6'd0,  8'h00, 2'b01, 1'b0, 14'h0000, 8'h00, 1'b1};
        vecs[5] = '{2'b01, 7'd0,  6'd60, 8'h46, 7'd0,  6'd0,  8'h00, 2'b01, 1'b0, 14'h0000, 8'h00, 1'b1};
        vecs[6] = '{2'b10, 7'd0,  6'd0,  8'h00, 7'd3,  6'd4,  8'h47, 2'b10, 1'b1, 14'h0203, 8'h47, 1'b0};
        vecs[7] = '{2'b00, 7'd1,  6'd1,  8'h11, 7'd2,  6'd2,  8'h22, 2'b00, 1'b0, 14'h0000, 8'h00, 1'b0};
        vecs[8] = '{2'b01, 7'd0,  6'd0,  8'h30, 7'd0,  6'd0,  8'h00, 2'b01, 1'b1, 14'h0000, 8'h30, 1'b0};

        resetN    = 1'b0;
        req_valid = 2'b00;
        req_col   = '0;
        req_row   = '0;
        req_char  = '0;
        clr_start = 1'b0;
        v_blank   = 1'b0;

        // Reset state, including a request held during reset.
        repeat (3) tick();
        req_valid = 2'b01;
        #1;
        check("reset_ready", req_ready, 2'b00);
        check("reset_text_add", text_add, 14'h0);
        check("reset_text_data", text_data, 8'h0);
        check("reset_wr_en", wr_en, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_clr_done", clr_done, 1'b0);
        check("reset_drop", drop, 1'b0);
        req_valid = 2'b00;
        resetN = 1'b1;
        tick();

        // Single-cycle requests from the table.
        for (int i = 0; i < 9; i++) begin
            req_valid   = vecs[i].v;
            req_col[0]  = vecs[i].c0;
            req_row[0]  = vecs[i].r0;
            req_char[0] = vecs[i].d0;
            req_col[1]  = vecs[i].c1;
            req_row[1]  = vecs[i].r1;
            req_char[1] = vecs[i].d1;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, vecs[i].rdy);
            tick();
            req_valid = 2'b00;
            check($sformatf("vec%0d_wr_en", i), wr_en, vecs[i].wr);
            check($sformatf("vec%0d_drop", i), drop, vecs[i].drp);
            if (vecs[i].wr) begin
                check($sformatf("vec%0d_text_add", i), text_add, vecs[i].add);
                check($sformatf("vec%0d_text_data", i), text_data, vecs[i].data);
            end
            tick();
        end

        // Fresh reset, then both requesters valid for four cycles: 0,1,0,1.
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        req_col[0] = 7'd1; req_row[0] = 6'd0; req_char[0] = 8'h50;
        req_col[1] = 7'd2; req_row[1] = 6'd0; req_char[1] = 8'h51;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("b2b%0d_ready", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            if (i == 3) begin
                tick();
                req_valid = 2'b00;
            end else begin
                tick();
            end
            check($sformatf("b2b%0d_wr_en", i), wr_en, 1'b1);
            check($sformatf("b2b%0d_text_data", i), text_data, (i % 2 == 0) ? 8'h50 : 8'h51);
            check($sformatf("b2b%0d_text_add", i), text_add, (i % 2 == 0) ? 14'h0001 : 14'h0002);
        end
        tick();

        // Full clear with requester 1 waiting the whole time.
        req_col[1] = 7'd9; req_row[1] = 6'd9; req_char[1] = 8'h5A;
        req_valid = 2'b10;
        clr_start = 1'b1;
        #1;
        check("clr_start_cycle_ready", req_ready, 2'b00);
        tick();
        clr_start = 1'b0;
        wr_cnt = 0; busy_cnt = 0; e_add = 0; e_rdy = 0; e_done = 0; guard = 0;
        mcol = 0; mrow = 0; last_add = '0;
        while (busy === 1'b1 && guard < 6000) begin
            if (wr_en === 1'b1) begin
                if (text_data !== 8'h20 || text_add !== {1'b0, 6'(mrow), 7'(mcol)}) e_add++;
                wr_cnt++;
                if (clr_done !== (wr_cnt == 4800)) e_done++;
                last_add = text_add;
                mcol++;
                if (mcol == 80) begin
                    mcol = 0;
                    mrow++;
                end
            end else begin
                e_add++;
                if (clr_done !== 1'b0) e_done++;
            end
            if (req_ready !== 2'b00) e_rdy++;
            busy_cnt++;
            tick();
            guard++;
        end
        check("clr_busy_fell", busy, 1'b0);
        check("clr_write_count", wr_cnt, 4800);
        check("clr_busy_cycles", busy_cnt, 4800);
        check("clr_addr_data_errors", e_add, 0);
        check("clr_done_errors", e_done, 0);
        check("clr_ready_errors", e_rdy, 0);
        check("clr_last_add", last_add, 14'h1DCF);
        check("post_clr_wr_en", wr_en, 1'b0);
        check("post_clr_done", clr_done, 1'b0);
        check("post_clr_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("pending_wr_en", wr_en, 1'b1);
        check("pending_text_add", text_add, 14'h0489);
        check("pending_text_data", text_data, 8'h5A);
        tick();

        // Reset in the middle of a clear.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        req_valid = 2'b01;
        repeat (100) tick();
        check("midclr_busy", busy, 1'b1);
        #5;
        resetN = 1'b0;
        #1;
        check("midclr_rst_ready", req_ready, 2'b00);
        check("midclr_rst_text_add", text_add, 14'h0);
        check("midclr_rst_text_data", text_data, 8'h0);
        check("midclr_rst_wr_en", wr_en, 1'b0);
        check("midclr_rst_busy", busy, 1'b0);
        check("midclr_rst_clr_done", clr_done, 1'b0);
        check("midclr_rst_drop", drop, 1'b0);
        tick();
        resetN = 1'b1;
        #1;
        check("midclr_idle_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("midclr_idle_wr_en", wr_en, 1'b1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
